// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus between the memory controller (master) and the
// RAM/IO responder (slave).
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_write;
  logic        is_write;
  logic [7:0]  mem_result;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_write, is_write,
    input  mem_result, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_write, is_write,
    output mem_result, io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped IO window (TX FIFO, status, program end) behind
// the controller's byte bus. Optional RX FIFO enabled by defining RX_FIFO_EN.
module mem_io_responder #(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  mem_io_responder_if.slave   bus,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  output logic                prog_end,
  output logic [7:0]          end_code,
  output logic                tx_overflow
);

  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_PW + 1;
  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
  localparam logic [TX_CW-1:0] TX_HIGH_CNT = TX_CW'(TX_DEPTH - 2);

  // Address decode and bus strobes; nothing on the bus side acts while rdy is low.
  logic              io_sel;
  logic [15:0]       io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              bus_wr;
  logic              bus_rd;
  logic              ram_we;
  logic              ram_re;
  logic              tx_push_req;
  logic              end_we;
  logic              rx_pop_req;

  assign io_sel      = (bus.mem_a[17:16] == 2'b11);
  assign io_off      = bus.mem_a[15:0];
  assign ram_idx     = bus.mem_a[RAM_AW-1:0];
  assign bus_wr      = rdy && bus.is_write;
  assign bus_rd      = rdy && !bus.is_write;
  assign ram_we      = bus_wr && !io_sel;
  assign ram_re      = bus_rd && !io_sel;
  assign tx_push_req = bus_wr && io_sel && (io_off == 16'h0000);
  assign end_we      = bus_wr && io_sel && (io_off == 16'h0004);
  assign rx_pop_req  = bus_rd && io_sel && (io_off == 16'h0000);

  logic bus_unused;
  assign bus_unused = ^bus.mem_a;

  // RAM: single port, registered read, contents survive reset.
  logic [7:0] ram [2**RAM_AW];
  logic [7:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.mem_write;
    if (ram_re) ram_rd_q <= ram[ram_idx];
  end

  // RX side: provides head byte and non-empty flag to the read mux.
  logic       rx_nonempty;
  logic [7:0] rx_head;

`ifdef RX_FIFO_EN
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_PW + 1;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RX_PW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_CW-1:0] rx_count_q, rx_count_d;
  logic             rx_push;
  logic             rx_pop;

  assign rx_ready    = (rx_count_q != RX_CW'(RX_DEPTH));
  assign rx_nonempty = (rx_count_q != '0);
  assign rx_head     = rx_mem[rx_rd_ptr_q];
  assign rx_push     = rx_valid && rx_ready;
  assign rx_pop      = rx_pop_req && rx_nonempty;

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q + RX_PW'(rx_push);
    rx_rd_ptr_d = rx_rd_ptr_q + RX_PW'(rx_pop);
    rx_count_d  = rx_count_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
  end
`else
  localparam int rx_depth_unused = RX_DEPTH;
  logic rx_unused;

  assign rx_ready    = 1'b0;
  assign rx_nonempty = 1'b0;
  assign rx_head     = 8'h00;
  assign rx_unused   = ^{rx_valid, rx_data, rx_pop_req};
`endif

  // TX FIFO storage; a push is accepted when full only if the sink pops the same cycle.
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TX_PW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_CW-1:0] tx_count_q, tx_count_d;
  logic             tx_pop;
  logic             tx_push;

  assign tx_valid = (tx_count_q != '0);
  assign tx_data  = tx_valid ? tx_mem[tx_rd_ptr_q] : 8'h00;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = tx_push_req && ((tx_count_q != TX_FULL_CNT) || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= bus.mem_write;
  end

  // Bus-side registers: read source select, IO read byte, flags.
  logic       src_ram_q, src_ram_d;
  logic [7:0] io_rd_q, io_rd_d;
  logic       io_full_q, io_full_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       prog_end_q, prog_end_d;
  logic [7:0] end_code_q, end_code_d;

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + TX_PW'(tx_push);
    tx_rd_ptr_d = tx_rd_ptr_q + TX_PW'(tx_pop);
    tx_count_d  = tx_count_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
    io_full_d   = (tx_count_d >= TX_HIGH_CNT);
    tx_ovf_d    = tx_ovf_q || (tx_push_req && !tx_push);
    prog_end_d  = prog_end_q || end_we;
    end_code_d  = end_we ? bus.mem_write : end_code_q;

    src_ram_d = src_ram_q;
    io_rd_d   = io_rd_q;
    if (bus_rd) begin
      if (!io_sel) begin
        src_ram_d = 1'b1;
      end else begin
        src_ram_d = 1'b0;
        io_rd_d   = 8'h00;
        if (io_off == 16'h0000)
          io_rd_d = rx_nonempty ? rx_head : 8'h00;
        else if (io_off == 16'h0004)
          io_rd_d = {6'b0, rx_nonempty, (tx_count_q == '0)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      src_ram_q   <= 1'b0;
      io_rd_q     <= 8'h00;
      io_full_q   <= 1'b0;
      tx_ovf_q    <= 1'b0;
      prog_end_q  <= 1'b0;
      end_code_q  <= 8'h00;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      src_ram_q   <= src_ram_d;
      io_rd_q     <= io_rd_d;
      io_full_q   <= io_full_d;
      tx_ovf_q    <= tx_ovf_d;
      prog_end_q  <= prog_end_d;
      end_code_q  <= end_code_d;
    end
  end

  // src_ram_q clears on reset, so stale RAM read data never reaches the bus.
  assign bus.mem_result     = src_ram_q ? ram_rd_q : io_rd_q;
  assign bus.io_buffer_full = io_full_q;
  assign tx_overflow        = tx_ovf_q;
  assign prog_end           = prog_end_q;
  assign end_code           = end_code_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, TX FIFO, status,
// program end, rdy freeze, asynchronous reset and (optionally) the RX FIFO.
module tb_mem_io_responder;
  logic       clk;
  logic       rst;
  logic       rdy;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       prog_end;
  logic [7:0] end_code;
  logic       tx_overflow;

  int checks = 0;
  int errors = 0;

  mem_io_responder_if bus_if ();

  mem_io_responder dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .bus         (bus_if),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .prog_end    (prog_end),
    .end_code    (end_code),
    .tx_overflow (tx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one bus transfer, then advance to 1 ns past the next rising edge.
  task automatic bus_op(input logic w, input logic [31:0] a, input logic [7:0] d);
    bus_if.is_write  = w;
    bus_if.mem_a     = a;
    bus_if.mem_write = d;
    @(posedge clk);
    #1;
    $display("bus %s addr=%h data=%h -> mem_result=%h", w ? "WR" : "RD", a, d, bus_if.mem_result);
  endtask

  task automatic bus_idle();
    bus_op(1'b0, 32'h0003_0008, 8'h00);
  endtask

  task automatic test_reset();
    checks++; if (bus_if.mem_result !== 8'h00) begin errors++; $display("FAIL reset_mem_result got %h want 00", bus_if.mem_result); end
    checks++; if (bus_if.io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_io_full got %b want 0", bus_if.io_buffer_full); end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx got v=%b d=%h want 0/00", tx_valid, tx_data); end
    checks++; if (prog_end !== 1'b0 || end_code !== 8'h00) begin errors++; $display("FAIL reset_prog_end got %b/%h want 0/00", prog_end, end_code); end
    checks++; if (tx_overflow !== 1'b0 || rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ovf_rx got ovf=%b rx_ready=%b want 0/0", tx_overflow, rx_ready); end
  endtask

  task automatic test_ram();
    bus_op(1'b1, 32'h0000_0010, 8'hA5);
    checks++; if (bus_if.mem_result !== 8'h00) begin errors++; $display("FAIL ram_write_no_result got %h want 00", bus_if.mem_result); end
    bus_op(1'b0, 32'h0000_0010, 8'h00);
    checks++; if (bus_if.mem_result !== 8'hA5) begin errors++; $display("FAIL ram_read_after_write got %h want a5", bus_if.mem_result); end
    bus_op(1'b0, 32'h0002_0010, 8'h00);
    checks++; if (bus_if.mem_result !== 8'hA5) begin errors++; $display("FAIL ram_wrap got %h want a5", bus_if.mem_result); end
    bus_op(1'b1, 32'h0000_0011, 8'h3C);
    bus_op(1'b1, 32'h0000_0020, 8'h11);
    bus_op(1'b0, 32'h0000_0011, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h3C) begin errors++; $display("FAIL ram_b2b_first got %h want 3c", bus_if.mem_result); end
    bus_op(1'b0, 32'h0000_0010, 8'h00);
    checks++; if (bus_if.mem_result !== 8'hA5) begin errors++; $display("FAIL ram_b2b_second got %h want a5", bus_if.mem_result); end
    bus_op(1'b0, 32'h0000_0020, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h11) begin errors++; $display("FAIL ram_b2b_third got %h want 11", bus_if.mem_result); end
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h01) begin errors++; $display("FAIL status_empty got %h want 01", bus_if.mem_result); end
    bus_idle();
    checks++; if (bus_if.mem_result !== 8'h00) begin errors++; $display("FAIL io_other_read got %h want 00", bus_if.mem_result); end
  endtask

  task automatic test_tx_fifo();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_op(1'b1, 32'h0003_0000, 8'(8'h41 + i));
      checks++; if (bus_if.io_buffer_full !== (i + 1 >= 6)) begin errors++; $display("FAIL tx_fill_io_full push=%0d got %b want %b", i + 1, bus_if.io_buffer_full, (i + 1 >= 6)); end
    end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL tx_head got v=%b d=%h want 1/41", tx_valid, tx_data); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL tx_no_early_ovf got %b want 0", tx_overflow); end
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h00) begin errors++; $display("FAIL status_nonempty got %h want 00", bus_if.mem_result); end
    bus_op(1'b1, 32'h0003_0000, 8'h49);
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL tx_overflow got %b want 1", tx_overflow); end
    bus_idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin errors++; $display("FAIL tx_drain idx=%0d got v=%b d=%h want 1/%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
      bus_idle();
      checks++; if (bus_if.io_buffer_full !== (7 - i >= 6)) begin errors++; $display("FAIL tx_drain_io_full idx=%0d got %b want %b", i, bus_if.io_buffer_full, (7 - i >= 6)); end
    end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL tx_empty got v=%b d=%h want 0/00", tx_valid, tx_data); end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_op(1'b1, 32'h0003_0000, 8'(8'h61 + i));
    tx_ready = 1'b1;
    bus_op(1'b1, 32'h0003_0000, 8'h69);
    checks++; if (bus_if.io_buffer_full !== 1'b1) begin errors++; $display("FAIL push_pop_full_count got io_full=%b want 1", bus_if.io_buffer_full); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h62 + i)) begin errors++; $display("FAIL push_pop_drain idx=%0d got v=%b d=%h want 1/%h", i, tx_valid, tx_data, 8'(8'h62 + i)); end
      bus_idle();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL push_pop_empty got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_prog_end();
    bus_op(1'b1, 32'h0003_0004, 8'h07);
    checks++; if (prog_end !== 1'b1 || end_code !== 8'h07) begin errors++; $display("FAIL prog_end got %b/%h want 1/07", prog_end, end_code); end
    bus_op(1'b1, 32'h0003_0004, 8'h09);
    checks++; if (prog_end !== 1'b1 || end_code !== 8'h09) begin errors++; $display("FAIL end_code_update got %b/%h want 1/09", prog_end, end_code); end
    bus_op(1'b1, 32'h0003_0008, 8'h55);
    checks++; if (end_code !== 8'h09 || tx_valid !== 1'b0) begin errors++; $display("FAIL io_other_write got end=%h v=%b want 09/0", end_code, tx_valid); end
  endtask

  task automatic test_rdy_hold();
    bus_op(1'b0, 32'h0000_0010, 8'h00);
    rdy = 1'b0;
    bus_op(1'b1, 32'h0000_0020, 8'hEE);
    checks++; if (bus_if.mem_result !== 8'hA5) begin errors++; $display("FAIL rdy_hold_write got %h want a5", bus_if.mem_result); end
    bus_op(1'b0, 32'h0000_0011, 8'h00);
    checks++; if (bus_if.mem_result !== 8'hA5) begin errors++; $display("FAIL rdy_hold_read got %h want a5", bus_if.mem_result); end
    bus_op(1'b1, 32'h0003_0000, 8'h77);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rdy_no_push got %b want 0", tx_valid); end
    rdy = 1'b1;
    bus_op(1'b0, 32'h0000_0020, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h11) begin errors++; $display("FAIL rdy_ram_unchanged got %h want 11", bus_if.mem_result); end
  endtask

  task automatic test_reset_mid();
    bus_op(1'b0, 32'h0000_0010, 8'h00);
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) bus_op(1'b1, 32'h0003_0000, 8'(8'h21 + i));
    checks++; if (bus_if.io_buffer_full !== 1'b1 || bus_if.mem_result !== 8'hA5) begin errors++; $display("FAIL pre_reset got full=%b res=%h want 1/a5", bus_if.io_buffer_full, bus_if.mem_result); end
    tx_ready = 1'b1;
    bus_idle();
    #2 rst = 1'b0;
    #1;
    checks++; if (bus_if.mem_result !== 8'h00 || bus_if.io_buffer_full !== 1'b0) begin errors++; $display("FAIL async_reset_bus got res=%h full=%b want 00/0", bus_if.mem_result, bus_if.io_buffer_full); end
    checks++; if (tx_valid !== 1'b0 || prog_end !== 1'b0 || end_code !== 8'h00 || tx_overflow !== 1'b0) begin errors++; $display("FAIL async_reset_out got v=%b pe=%b ec=%h ovf=%b want all 0", tx_valid, prog_end, end_code, tx_overflow); end
    @(posedge clk);
    #1 rst = 1'b1;
    tx_ready = 1'b0;
    bus_op(1'b0, 32'h0000_0010, 8'h00);
    checks++; if (bus_if.mem_result !== 8'hA5) begin errors++; $display("FAIL ram_kept_after_reset got %h want a5", bus_if.mem_result); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty_after_reset got %b want 0", tx_valid); end
  endtask

  task automatic test_rx();
`ifdef RX_FIFO_EN
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_empty got %b want 1", rx_ready); end
    rx_valid = 1'b1;
    rx_data  = 8'h31;
    bus_idle();
    rx_data  = 8'h32;
    bus_idle();
    rx_valid = 1'b0;
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h03) begin errors++; $display("FAIL rx_status got %h want 03", bus_if.mem_result); end
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h31) begin errors++; $display("FAIL rx_pop1 got %h want 31", bus_if.mem_result); end
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h32) begin errors++; $display("FAIL rx_pop2 got %h want 32", bus_if.mem_result); end
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h00) begin errors++; $display("FAIL rx_pop_empty got %h want 00", bus_if.mem_result); end
`else
    rx_valid = 1'b1;
    rx_data  = 8'h31;
    bus_op(1'b0, 32'h0000_0010, 8'h00);
    rx_valid = 1'b0;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_tied got %b want 0", rx_ready); end
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h00) begin errors++; $display("FAIL rx_read_zero got %h want 00", bus_if.mem_result); end
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    checks++; if (bus_if.mem_result !== 8'h01) begin errors++; $display("FAIL rx_status_bit got %h want 01", bus_if.mem_result); end
`endif
  endtask

  initial begin
    rst              = 1'b0;
    rdy              = 1'b1;
    tx_ready         = 1'b0;
    rx_valid         = 1'b0;
    rx_data          = 8'h00;
    bus_if.mem_a     = 32'h0003_0008;
    bus_if.mem_write = 8'h00;
    bus_if.is_write  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    test_ram();
    test_tx_fifo();
    test_back_to_back();
    test_prog_end();
    test_rdy_hold();
    test_reset_mid();
    test_rx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 ns");
    $fatal(1);
  end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the byte-wide memory bus driven by the memory controller (`mem_a`, `mem_write`, `is_write`, `mem_result`, `cannot_read`).
- Serves a single-port byte RAM with a registered 1-cycle read latency.
- Serves a memory-mapped IO window containing a TX byte FIFO, a status byte and a program-end register.
- Drives `io_buffer_full` (the controller's `cannot_read` input) so the initiator stalls before the TX FIFO overflows.

Parameters:
- RAM_AW, 17: RAM address width; RAM size is 2^RAM_AW bytes.
- TX_DEPTH, 8: TX FIFO entries; power of two, >= 4.
- RX_DEPTH, 8: RX FIFO entries; power of two. Used only when RX_FIFO_EN is defined.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous, active-low reset.
- rdy  in  1  Global enable. When low, all bus-side state is frozen.
- mem_a  in  32  Byte address from the initiator.
- mem_write  in  8  Write data byte.
- is_write  in  1  1 = write, 0 = read.
- mem_result  out  8  Read data, valid the cycle after the address is presented.
- io_buffer_full  out  1  Stall request to the initiator.
- tx_valid  out  1  TX FIFO non-empty.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  Downstream sink accepts the head byte.
- rx_valid  in  1  Inbound byte available (RX_FIFO_EN only).
- rx_data  in  8  Inbound byte (RX_FIFO_EN only).
- rx_ready  out  1  RX FIFO can accept a byte (RX_FIFO_EN only; tie to 0 otherwise).
- prog_end  out  1  Sticky; set when the program writes 0x30004.
- end_code  out  8  Byte written to 0x30004.
- tx_overflow  out  1  Sticky; set when a write to a full TX FIFO is dropped.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, TX/RX FIFO pointers and counts 0. RAM contents are not reset.
- Decode:
  - IO space when mem_a[17:16]==2'b11.
  - Otherwise RAM, indexed by mem_a[RAM_AW-1:0]; upper bits are ignored, so addresses wrap.
- Bus accesses (only when rdy=1):
  - RAM write: mem[idx] <= mem_write on the clock edge.
  - RAM read: mem_result <= mem[idx] on the same edge, so data is visible one cycle later.
  - Back-to-back reads are allowed one per cycle.
  - A read of the address written in the previous cycle returns the new byte.
- IO write 0x30000:
  - Push mem_write into the TX FIFO.
  - If the FIFO is full, drop the byte and set tx_overflow.
- IO write 0x30004: prog_end <= 1, end_code <= mem_write. Later writes update end_code.
- IO read 0x30000: pop RX FIFO; mem_result <= head, or 0x00 if empty. Without RX_FIFO_EN it always returns 0x00.
- IO read 0x30004: mem_result <= {6'b0, rx_nonempty, tx_empty}.
- Other IO addresses: reads return 0x00; writes are ignored.
- io_buffer_full:
  - Registered; equals (tx_count >= TX_DEPTH-2) after each edge.
  - The 2-entry margin absorbs the initiator's 1-cycle address pipeline plus the write in flight.
- TX drain:
  - tx_valid = tx_count != 0; tx_data = head.
  - Pop on tx_valid && tx_ready. The drain is independent of rdy.
  - Push and pop in the same cycle leave tx_count unchanged; a push is accepted in that cycle even when the FIFO is full, because the pop frees a slot.
  - Pointers wrap modulo TX_DEPTH.
- rdy=0: no RAM write, no bus push/pop, mem_result held. The TX drain and RX fill continue.
- Reset mid-operation: any in-flight read data is lost, FIFOs are emptied, and RAM keeps its contents.

Optional Feature:
- Macro: RX_FIFO_EN.
- Defined:
  - RX FIFO of RX_DEPTH entries.
  - rx_ready = rx_count != RX_DEPTH; push on rx_valid && rx_ready.
  - A simultaneous push and bus pop leaves rx_count unchanged.
- Not defined:
  - No RX storage; rx_ready = 0.
  - Reads of 0x30000 return 0x00.
  - Status bit1 = 0.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 in the next cycle -> mem_result = 0xA5 exactly one cycle after the read address.
- Read 0x20010 (RAM_AW=17) -> returns the byte stored at 0x00010 (wrap).
- With tx_ready=0, write 0x41..0x48 to 0x30000 -> io_buffer_full rises after the 6th push, the 8th byte is stored, and a 9th write sets tx_overflow=1. Then raise tx_ready -> tx_data drains 0x41..0x48 in order, one per cycle, and io_buffer_full falls when tx_count < 6.
- Write 0x07 to 0x30004 -> prog_end=1 and end_code=0x07 next cycle. Assert rst=0 mid-drain -> all outputs 0 immediately, and a read of 0x00010 afterwards still returns 0xA5.
- rdy=0 while is_write=1 to 0x00020 -> RAM unchanged and mem_result held.
- RX_FIFO_EN: push 0x31, 0x32 via rx_valid, then read 0x30000 twice and a third time -> mem_result = 0x31, 0x32, 0x00.
